i2s_dac_transmitter: RTL and testbench
======================================

// Module: i2s_dac_transmitter
// PURPOSE
//  Serialises stereo PCM samples from sinewave_generator (sinewave -> left, cosinewave -> right) onto an
//  I2S bus driving the external DAC. Generates BCLK/LRCLK from clk, and issues the one-cycle sample_ce
//  strobe that advances the generator's phase accumulator once per frame (ties to its sample_clk_ce).
// PARAMETERS
//  DATA_WIDTH   16  sample width in bits; must be >= 1 and <= SLOT_WIDTH-1.
//  SLOT_WIDTH   32  BCLK periods per channel slot; frame = 2*SLOT_WIDTH BCLK periods.
//  BCLK_DIV      4  clk cycles per BCLK period; must be even and >= 2.
// PORTS
//  clk           in   1           system clock; all logic on its rising edge.
//  arst_n        in   1           asynchronous active-low reset.
//  enable        in   1           1 = run the bus; 0 = idle and abort any frame in flight.
//  left_sample   in   DATA_WIDTH  left PCM word, two's complement; captured at frame start.
//  right_sample  in   DATA_WIDTH  right PCM word, two's complement; captured at frame start.
//  sample_ce     out  1           one-clk pulse at each frame start; source must advance on it.
//  busy          out  1           1 while in RUN.
//  i2s_bclk      out  1           bit clock; 50% duty, period BCLK_DIV clk cycles.
//  i2s_lrclk     out  1           word select; 0 = left slot, 1 = right slot.
//  i2s_sdata     out  1           serial data, MSB first; changes on BCLK falling edge only.
// BEHAVIOUR
//  - Reset (arst_n=0): state=IDLE; all outputs 0; div_cnt, bit_cnt, shadow regs cleared. Async assert, sync release.
//  - All outputs registered. States: IDLE, RUN.
//  - IDLE -> RUN on first clk edge with enable=1; that edge is frame start (div_cnt=0, bit_cnt=0).
//  - RUN -> IDLE on any edge with enable=0: next cycle all outputs 0, counters cleared, no sample_ce.
//  - div_cnt counts 0..BCLK_DIV-1 and wraps; i2s_bclk = 0 for div_cnt < BCLK_DIV/2, 1 otherwise.
//  - BCLK falling edge = edge where div_cnt wraps to 0; bit_cnt (0..2*SLOT_WIDTH-1) advances there and wraps.
//  - i2s_lrclk = (bit_cnt >= SLOT_WIDTH); k = bit_cnt mod SLOT_WIDTH.
//  - Frame start = IDLE->RUN edge, or falling edge where bit_cnt wraps to 0. On that edge: sample_ce=1 for
//    exactly one cycle; left/right shadow regs load from left_sample/right_sample (values present that cycle).
//    sample_ce period in RUN = 2*SLOT_WIDTH*BCLK_DIV clk cycles exactly.
//  - Data bits (default I2S, 1-BCLK delay): k=1..DATA_WIDTH carry shadow MSB..LSB; all other k output 0.
//    Left bit for k=0 of frame start uses shadow value being loaded (bypass), never stale data.
//  - Input changes between frame starts have no effect on the frame in flight.
//  - Reset mid-frame: immediate idle; after release, restart as IDLE->RUN (fresh frame, fresh sample_ce).
// CONFIGURATION
//  Macro I2S_LEFT_JUSTIFIED_EN:
//   defined   -> left-justified: MSB..LSB on k=0..DATA_WIDTH-1 (no delay); DATA_WIDTH may equal SLOT_WIDTH.
//   undefined -> Philips I2S as above (MSB at k=1). LRCLK, BCLK, sample_ce timing identical in both.
// STRUCTURE
//  - Package i2s_pkg: state enum (IDLE, RUN); localparams FRAME_BITS=2*SLOT_WIDTH, HALF_DIV=BCLK_DIV/2,
//    DATA_OFFSET (1 for I2S, 0 for LJ); width helpers via $clog2.
//  - Sub-module i2s_clk_div: div_cnt, bclk generation, one-cycle fall_tick output; rest in top.
//  - Elaboration-time check: BCLK_DIV even >= 2, DATA_WIDTH+DATA_OFFSET <= SLOT_WIDTH.
// TESTING  (DATA_WIDTH=16, SLOT_WIDTH=32, BCLK_DIV=4 unless stated)
//  1. Reset then enable=1, left=16'hA5F0, right=16'h0001 held -> sample_ce every 256 clks, bclk period 4,
//     lrclk period 256; bits after left slot start decode 1010_0101_1111_0000, right decodes 16'h0001, pad 0.
//  2. Change left to 16'h1234 mid-left-slot -> current frame still sends A5F0; next frame sends 1234.
//  3. Drop enable at bit_cnt=40 -> next cycle bclk/lrclk/sdata/busy=0; re-enable -> sample_ce same edge, clean frame.
//  4. arst_n pulse mid-right-slot -> all outputs 0 during reset; first frame after release complete and correct.
//  5. I2S_LEFT_JUSTIFIED_EN defined, left=16'h8000 -> sdata=1 on first left bit (k=0), 0 for k=1..31.
//  6. BCLK_DIV=2, SLOT_WIDTH=17 -> bclk toggles every clk; sample_ce period 68; LSB lands on k=16, k=0 is 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types, defaults and width helpers for the I2S DAC transmitter.
// Build macro I2S_LEFT_JUSTIFIED_EN selects left-justified framing (default: Philips I2S).
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SLOT_WIDTH = 32;
    localparam int DEF_BCLK_DIV   = 4;
    localparam int FRAME_BITS     = 2 * DEF_SLOT_WIDTH;
    localparam int HALF_DIV       = DEF_BCLK_DIV / 2;

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int DATA_OFFSET = 0;
`else
    localparam int DATA_OFFSET = 1;
`endif

    function automatic int cbits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int frame_bits(input int slot_width);
        return 2 * slot_width;
    endfunction

    function automatic int half_div(input int bclk_div);
        return bclk_div / 2;
    endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK divider: div_cnt, registered bit clock and a fall tick that
// marks the edge on which div_cnt wraps (BCLK falling edge).
module i2s_clk_div
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_adv,
    output logic o_bclk,
    output logic o_fall_tick
);

    localparam int DW = cbits(BCLK_DIV);
    localparam logic [DW-1:0] DIV_MAX  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(half_div(BCLK_DIV));

    logic [DW-1:0] r_div_cnt;
    logic [DW-1:0] w_div_nxt;
    logic          r_bclk;

    always_comb begin
        w_div_nxt = '0;
        if (i_adv && (r_div_cnt != DIV_MAX))
            w_div_nxt = r_div_cnt + 1'b1;
    end

    assign o_fall_tick = i_adv && (r_div_cnt == DIV_MAX);
    assign o_bclk      = r_bclk;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_bclk    <= (w_div_nxt >= DIV_HALF);
        end
    end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// Stereo I2S transmitter with per-frame sample_ce strobe to the sample source.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified data; default is Philips I2S.
module i2s_dac_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
    parameter int BCLK_DIV   = DEF_BCLK_DIV
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] left_sample,
    input  logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_ce,
    output logic                  busy,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata
);

    localparam int FRM_BITS = frame_bits(SLOT_WIDTH);
    localparam int BW       = cbits(FRM_BITS);
    localparam logic [BW-1:0] BIT_MAX  = BW'(FRM_BITS - 1);
    localparam logic [BW-1:0] SLOT_LIM = BW'(SLOT_WIDTH);

    if ((BCLK_DIV < 2) || ((BCLK_DIV % 2) != 0) || (DATA_WIDTH < 1) ||
        ((DATA_WIDTH + DATA_OFFSET) > SLOT_WIDTH)) begin : g_bad_cfg
        $error("i2s_dac_transmitter: illegal parameter combination");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic [BW-1:0]         w_bit_nxt;
    logic [BW-1:0]         w_k;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic [DATA_WIDTH-1:0] w_left_nxt;
    logic [DATA_WIDTH-1:0] w_right_nxt;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_adv;
    logic                  w_fall;
    logic                  w_start;
    logic                  w_rslot;
    logic                  w_sbit;
    logic                  r_sample_ce;
    logic                  r_busy;
    logic                  r_lrclk;
    logic                  r_sdata;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        unique case (r_state)
            IDLE:    if (enable) w_state_nxt = RUN;
            RUN:     if (enable) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_adv = (r_state == RUN) && enable;

    i2s_clk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_div (
        .i_clk       (clk),
        .i_arst_n    (arst_n),
        .i_adv       (w_adv),
        .o_bclk      (i2s_bclk),
        .o_fall_tick (w_fall)
    );

    assign w_start = enable &&
                     ((r_state == IDLE) || (w_fall && (r_bit_cnt == BIT_MAX)));

    always_comb begin
        w_bit_nxt = '0;
        if (w_adv) begin
            w_bit_nxt = r_bit_cnt;
            if (w_fall)
                w_bit_nxt = (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + 1'b1;
        end
    end

    assign w_left_nxt  = w_start ? left_sample  : r_left;
    assign w_right_nxt = w_start ? right_sample : r_right;

    // Data is picked from the post-edge bit position and shadow value,
    // so the first left bit of a frame sees the word being loaded.
    always_comb begin
        w_rslot = (w_bit_nxt >= SLOT_LIM);
        w_k     = w_rslot ? (w_bit_nxt - SLOT_LIM) : w_bit_nxt;
        w_word  = w_rslot ? w_right_nxt : w_left_nxt;
        w_sbit  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_k == BW'(DATA_OFFSET + i))
                w_sbit = w_word[DATA_WIDTH-1-i];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_bit_cnt   <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_sample_ce <= 1'b0;
            r_busy      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
        end else begin
            r_bit_cnt   <= w_bit_nxt;
            r_left      <= w_left_nxt;
            r_right     <= w_right_nxt;
            r_sample_ce <= w_start;
            r_busy      <= (w_state_nxt == RUN);
            r_lrclk     <= enable && w_rslot;
            r_sdata     <= enable && w_sbit;
        end
    end

    assign sample_ce = r_sample_ce;
    assign busy      = r_busy;
    assign i2s_lrclk = r_lrclk;
    assign i2s_sdata = r_sdata;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for i2s_dac_transmitter (DATA_WIDTH=16, SLOT_WIDTH=32, BCLK_DIV=4).
// Honors I2S_LEFT_JUSTIFIED_EN for the expected data offset.
module tb_i2s_dac_transmitter;

    localparam int DW  = 16;
    localparam int SW  = 32;
    localparam int DIV = 4;
    localparam int FRM = 2 * SW * DIV;
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    logic          clk = 1'b0;
    logic          arst_n;
    logic          enable;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic          sample_ce;
    logic          busy;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;

    int n_pass = 0;
    int n_tot  = 0;

    i2s_dac_transmitter #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .BCLK_DIV   (DIV)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_ce    (sample_ce),
        .busy         (busy),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " sample_ce"}, 32'(sample_ce), 32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " bclk"},      32'(i2s_bclk),  32'd0);
        chk({tag, " lrclk"},     32'(i2s_lrclk), 32'd0);
        chk({tag, " sdata"},     32'(i2s_sdata), 32'd0);
    endtask

    // Entered just after a frame-start edge; leaves at the next one.
    task automatic run_frame(input string tag, input logic [DW-1:0] el,
                             input logic [DW-1:0] er, input int chg_at,
                             input logic [DW-1:0] chg_val);
        logic [DW-1:0] dl;
        logic [DW-1:0] dr;
        logic [DW-1:0] w;
        int            dv, b, k;
        logic          es;
        dl = '0;
        dr = '0;
        for (int c = 0; c < FRM; c++) begin
            dv = c % DIV;
            b  = c / DIV;
            k  = b % SW;
            w  = (b >= SW) ? er : el;
            es = 1'b0;
            if (k >= OFF && k < OFF + DW)
                es = 1'((w >> (DW - 1 - (k - OFF))) & 16'd1);
            chk($sformatf("%s ce c=%0d", tag, c),    32'(sample_ce), 32'(c == 0));
            chk($sformatf("%s busy c=%0d", tag, c),  32'(busy),      32'd1);
            chk($sformatf("%s bclk c=%0d", tag, c),  32'(i2s_bclk),  32'(dv >= DIV / 2));
            chk($sformatf("%s lrclk c=%0d", tag, c), 32'(i2s_lrclk), 32'(b >= SW));
            chk($sformatf("%s sdata c=%0d", tag, c), 32'(i2s_sdata), 32'(es));
            if (dv == 2 && k >= OFF && k < OFF + DW) begin
                if (b < SW) dl = {dl[DW-2:0], i2s_sdata};
                else        dr = {dr[DW-2:0], i2s_sdata};
            end
            if (c == chg_at) left_sample = chg_val;
            tick();
        end
        chk({tag, " left word"},  32'(dl), 32'(el));
        chk({tag, " right word"}, 32'(dr), 32'(er));
    endtask

    initial begin
        arst_n       = 1'b0;
        enable       = 1'b0;
        left_sample  = 16'hA5F0;
        right_sample = 16'h0001;
        #12;
        chk_idle("reset");
        arst_n = 1'b1;
        tick();
        chk_idle("idle no enable");

        // Frame 1: A5F0 / 0001 held
        enable = 1'b1;
        tick();
        run_frame("f1", 16'hA5F0, 16'h0001, -1, 16'h0000);

        // Frame 2: left changes mid-left-slot, takes effect next frame
        run_frame("f2", 16'hA5F0, 16'h0001, 40, 16'h1234);
        run_frame("f3", 16'h1234, 16'h0001, -1, 16'h0000);

        // Drop enable at bit_cnt=40
        for (int c = 0; c < 40 * DIV; c++) tick();
        enable = 1'b0;
        tick();
        chk_idle("disable 1");
        tick();
        chk_idle("disable 2");
        enable = 1'b1;
        tick();
        run_frame("f4", 16'h1234, 16'h0001, -1, 16'h0000);

        // Async reset pulse in the right slot
        for (int c = 0; c < 37 * DIV + 2; c++) tick();
        chk("pre-reset lrclk", 32'(i2s_lrclk), 32'd1);
        #2;
        arst_n       = 1'b0;
        left_sample  = 16'hFFFF;
        right_sample = 16'h8000;
        #1;
        chk_idle("async reset");
        tick();
        chk_idle("held reset");
        #2;
        arst_n = 1'b1;
        tick();
        run_frame("f5", 16'hFFFF, 16'h8000, -1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
